// File: rtl/hazard_unit_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds register width, forward-select encoding and mul/div latencies.
package hazard_unit_pkg;

   localparam int REG_BITS    = 5;
   localparam int DEF_MUL_LAT = 4;
   localparam int DEF_DIV_LAT = 32;

   typedef logic [REG_BITS-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // Memory stage wins over writeback; r0 is hardwired zero.
   function automatic fwd_sel_t fwd_sel(
      input reg_idx_t src,
      input reg_idx_t wr_m,
      input logic     we_m,
      input reg_idx_t wr_w,
      input logic     we_w
   );
      if (src == '0)
         return FWD_RF;
      if (we_m && (wr_m == src))
         return FWD_MEM;
      if (we_w && (wr_w == src))
         return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard controller bundle.
// master: pipeline side (drives stage info); slave: hazard unit side.
// With HAZARD_STATS_EN defined, also carries the stall statistics.
interface hazard_unit_if;
   import hazard_unit_pkg::*;

   reg_idx_t rs_d;
   reg_idx_t rt_d;
   reg_idx_t rs_e;
   reg_idx_t rt_e;
   reg_idx_t write_reg_e;
   reg_idx_t write_reg_m;
   reg_idx_t write_reg_w;
   logic     reg_write_e;
   logic     reg_write_m;
   logic     reg_write_w;
   logic     mem_to_reg_e;
   logic     mem_to_reg_m;
   logic     branch_d;
   logic     md_start_e;
   logic     md_div_e;
   logic     md_use_d;

   fwd_sel_t forward_a_e;
   fwd_sel_t forward_b_e;
   logic     forward_a_d;
   logic     forward_b_d;
   logic     stall_f;
   logic     stall_d;
   logic     flush_e;
   logic     md_busy;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles;
   logic [31:0] md_stall_cycles;
`endif

   modport master (
      output rs_d, rt_d, rs_e, rt_e,
      output write_reg_e, write_reg_m, write_reg_w,
      output reg_write_e, reg_write_m, reg_write_w,
      output mem_to_reg_e, mem_to_reg_m,
      output branch_d, md_start_e, md_div_e, md_use_d,
      input  forward_a_e, forward_b_e,
      input  forward_a_d, forward_b_d,
      input  stall_f, stall_d, flush_e, md_busy
`ifdef HAZARD_STATS_EN
      , input stall_cycles, md_stall_cycles
`endif
   );

   modport slave (
      input  rs_d, rt_d, rs_e, rt_e,
      input  write_reg_e, write_reg_m, write_reg_w,
      input  reg_write_e, reg_write_m, reg_write_w,
      input  mem_to_reg_e, mem_to_reg_m,
      input  branch_d, md_start_e, md_div_e, md_use_d,
      output forward_a_e, forward_b_e,
      output forward_a_d, forward_b_d,
      output stall_f, stall_d, flush_e, md_busy
`ifdef HAZARD_STATS_EN
      , output stall_cycles, md_stall_cycles
`endif
   );

endinterface

// File: rtl/hazard_unit_md_busy_counter.sv
// Countdown tracking the multi-cycle mul/div unit (HI/LO).
// Ports: clk, reset (sync, high), md_start_e, md_div_e in; md_busy out.
module md_busy_counter #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start_e,
   input  logic md_div_e,
   output logic md_busy
);

   localparam int CW = $clog2(DIV_LAT + 1);
   localparam logic [CW-1:0] MUL_V = CW'(MUL_LAT);
   localparam logic [CW-1:0] DIV_V = CW'(DIV_LAT);

   logic [CW-1:0] r_md_cnt;
   logic          w_idle;

   assign w_idle = (r_md_cnt == '0);

   // A start while counting is ignored: no reload.
   always_ff @(posedge clk) begin
      if (reset)
         r_md_cnt <= '0;
      else if (md_start_e && w_idle)
         r_md_cnt <= md_div_e ? DIV_V : MUL_V;
      else if (!w_idle)
         r_md_cnt <= r_md_cnt - 1'b1;
   end

   assign md_busy = md_start_e || !w_idle;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: forwarding selects, load-use/branch/mul-div stalls.
// Ports: clk, reset (sync, high), hz (hazard_unit_if.slave).
// Define HAZARD_STATS_EN for stall_cycles / md_stall_cycles counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT
) (
   input logic          clk,
   input logic          reset,
   hazard_unit_if.slave hz
);

   logic w_md_busy;
   logic w_lw_stall;
   logic w_br_e;
   logic w_br_m;
   logic w_br_stall;
   logic w_md_stall;
   logic w_stall;

   md_busy_counter #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md (
      .clk        (clk),
      .reset      (reset),
      .md_start_e (hz.md_start_e),
      .md_div_e   (hz.md_div_e),
      .md_busy    (w_md_busy)
   );

   function automatic logic hits_d(input reg_idx_t dst);
      return (dst != '0) && ((dst == hz.rs_d) || (dst == hz.rt_d));
   endfunction

   assign hz.forward_a_e = fwd_sel(hz.rs_e,
      hz.write_reg_m, hz.reg_write_m,
      hz.write_reg_w, hz.reg_write_w);
   assign hz.forward_b_e = fwd_sel(hz.rt_e,
      hz.write_reg_m, hz.reg_write_m,
      hz.write_reg_w, hz.reg_write_w);

   assign hz.forward_a_d = (hz.rs_d != '0) && hz.reg_write_m
      && (hz.write_reg_m == hz.rs_d);
   assign hz.forward_b_d = (hz.rt_d != '0) && hz.reg_write_m
      && (hz.write_reg_m == hz.rt_d);

   assign w_lw_stall = hz.mem_to_reg_e && hits_d(hz.write_reg_e);
   // Compare in decode can't see an ALU result still in E,
   // nor a load result still in M.
   assign w_br_e = hz.reg_write_e && hits_d(hz.write_reg_e);
   assign w_br_m = hz.mem_to_reg_m && hits_d(hz.write_reg_m);
   assign w_br_stall = hz.branch_d && (w_br_e || w_br_m);
   assign w_md_stall = hz.md_use_d && w_md_busy;
   assign w_stall = w_lw_stall || w_br_stall || w_md_stall;

   assign hz.stall_f = w_stall;
   assign hz.stall_d = w_stall;
   assign hz.flush_e = w_stall;
   assign hz.md_busy = w_md_busy;

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_md_stall_cycles;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles    <= '0;
         r_md_stall_cycles <= '0;
      end else begin
         if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 1'b1;
         if (w_md_stall && (r_md_stall_cycles != '1))
            r_md_stall_cycles <= r_md_stall_cycles + 1'b1;
      end
   end

   assign hz.stall_cycles    = r_stall_cycles;
   assign hz.md_stall_cycles = r_md_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed cases plus random
// stimulus against a cycle-indexed behavioural model.
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   localparam int ML = 4;
   localparam int DL = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_unit_if hz();

   hazard_unit #(
      .MUL_LAT (ML),
      .DIV_LAT (DL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   // Model: cycle index and last cycle in which the unit
   // is still counting down after a start.
   int cyc = 0;
   int mdl_end = -1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(logic [4:0] src);
      if (src == 0) return 2'b00;
      if (hz.reg_write_m && hz.write_reg_m == src) return 2'b10;
      if (hz.reg_write_w && hz.write_reg_w == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit m_dep(logic [4:0] dst);
      return dst != 0 && (dst == hz.rs_d || dst == hz.rt_d);
   endfunction

   function automatic bit m_busy();
      return hz.md_start_e || (cyc <= mdl_end);
   endfunction

   function automatic bit m_stall();
      bit lw, br, md;
      lw = hz.mem_to_reg_e && m_dep(hz.write_reg_e);
      br = hz.branch_d &&
           ((hz.reg_write_e && m_dep(hz.write_reg_e)) ||
            (hz.mem_to_reg_m && m_dep(hz.write_reg_m)));
      md = hz.md_use_d && m_busy();
      return lw || br || md;
   endfunction

   function automatic bit m_fd(logic [4:0] src);
      return src != 0 && hz.reg_write_m && hz.write_reg_m == src;
   endfunction

   always @(posedge clk) begin
      if (!reset)
         assert (!(hz.md_start_e && cyc <= mdl_end))
            else $error("md_start_e issued while unit counting");
      if (reset)
         mdl_end <= cyc;
      else if (hz.md_start_e && cyc > mdl_end)
         mdl_end <= cyc + (hz.md_div_e ? DL : ML);
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("fwd_a_e", hz.forward_a_e, m_fwd(hz.rs_e));
         chk("fwd_b_e", hz.forward_b_e, m_fwd(hz.rt_e));
         chk("fwd_a_d", hz.forward_a_d, m_fd(hz.rs_d));
         chk("fwd_b_d", hz.forward_b_d, m_fd(hz.rt_d));
         chk("stall_f", hz.stall_f, m_stall());
         chk("stall_d", hz.stall_d, m_stall());
         chk("flush_e", hz.flush_e, m_stall());
         chk("md_busy", hz.md_busy, m_busy());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      hz.rs_d = 0; hz.rt_d = 0;
      hz.rs_e = 0; hz.rt_e = 0;
      hz.write_reg_e = 0;
      hz.write_reg_m = 0;
      hz.write_reg_w = 0;
      hz.reg_write_e = 0;
      hz.reg_write_m = 0;
      hz.reg_write_w = 0;
      hz.mem_to_reg_e = 0;
      hz.mem_to_reg_m = 0;
      hz.branch_d = 0;
      hz.md_start_e = 0;
      hz.md_div_e = 0;
      hz.md_use_d = 0;
   endtask

   task automatic chk_stall(string nm, logic exp);
      chk({nm, "_f"}, hz.stall_f, exp);
      chk({nm, "_d"}, hz.stall_d, exp);
      chk({nm, "_e"}, hz.flush_e, exp);
   endtask

   // Multiply with a dependent decode instruction held waiting.
   task automatic mul_run(output int n);
      bit seen;
      n = 0;
      seen = 0;
      clr();
      hz.md_start_e = 1;
      hz.md_use_d = 1;
      for (int i = 0; i < 40; i++) begin
         #1;
         chk("mul_busy_eq_stall", hz.md_busy, hz.stall_d);
         if (hz.stall_d) begin
            n++;
            seen = 1;
         end else if (seen) begin
            break;
         end
         tick();
         hz.md_start_e = 0;
      end
      clr();
   endtask

   initial begin
      int n;
      clr();
      reset = 1;
      chk_en = 1;
      tick();
      tick();
      reset = 0;
      #1;
      chk("rst_fwd_a_e", hz.forward_a_e, 2'b00);
      chk("rst_fwd_b_e", hz.forward_b_e, 2'b00);
      chk_stall("rst_stall", 1'b0);
      chk("rst_md_busy", hz.md_busy, 1'b0);
      tick();

      hz.rs_e = 8;
      hz.write_reg_m = 8; hz.reg_write_m = 1;
      hz.write_reg_w = 8; hz.reg_write_w = 1;
      #1 chk("fwd_prio_m", hz.forward_a_e, 2'b10);
      hz.reg_write_m = 0;
      #1 chk("fwd_prio_w", hz.forward_a_e, 2'b01);
      hz.reg_write_m = 1; hz.rs_e = 0;
      #1 chk("fwd_r0", hz.forward_a_e, 2'b00);
      tick();

      clr();
      hz.mem_to_reg_e = 1; hz.write_reg_e = 9; hz.rt_d = 9;
      #1 chk_stall("lw_stall", 1'b1);
      tick();
      clr();
      hz.write_reg_m = 9; hz.reg_write_m = 1;
      hz.mem_to_reg_m = 1; hz.rt_e = 9;
      #1 chk_stall("lw_after", 1'b0);
      chk("lw_fwd_b_e", hz.forward_b_e, 2'b10);
      tick();

      clr();
      hz.branch_d = 1; hz.rs_d = 5;
      hz.reg_write_e = 1; hz.write_reg_e = 5;
      #1 chk_stall("br_stall", 1'b1);
      tick();
      clr();
      hz.branch_d = 1; hz.rs_d = 5;
      hz.write_reg_m = 5; hz.reg_write_m = 1;
      #1 chk_stall("br_after", 1'b0);
      chk("br_fwd_a_d", hz.forward_a_d, 1'b1);
      tick();

      clr();
      tick();
      mul_run(n);
      chk("mul_stall_len", n, ML + 1);
      tick();

      clr();
      hz.md_start_e = 1; hz.md_div_e = 1;
      tick();
      clr();
      repeat (9) tick();
      #1 chk("div_busy_c10", hz.md_busy, 1'b1);
      reset = 1;
      tick();
      reset = 0;
      hz.md_use_d = 1;
      #1 chk("div_rst_busy", hz.md_busy, 1'b0);
      chk_stall("div_rst_stall", 1'b0);
      tick();
      clr();

`ifdef HAZARD_STATS_EN
      reset = 1;
      tick();
      reset = 0;
      for (int k = 0; k < 3; k++) begin
         clr();
         hz.mem_to_reg_e = 1; hz.write_reg_e = 7; hz.rs_d = 7;
         tick();
         clr();
         tick();
      end
      mul_run(n);
      tick();
      #1 chk("stat_stall", hz.stall_cycles, 32'd8);
      chk("stat_md_stall", hz.md_stall_cycles, 32'd5);
      tick();
`endif

      for (int k = 0; k < 3000; k++) begin
         hz.rs_d = 5'($urandom_range(0, 7));
         hz.rt_d = 5'($urandom_range(0, 7));
         hz.rs_e = 5'($urandom_range(0, 7));
         hz.rt_e = 5'($urandom_range(0, 7));
         hz.write_reg_e = 5'($urandom_range(0, 7));
         hz.write_reg_m = 5'($urandom_range(0, 7));
         hz.write_reg_w = 5'($urandom_range(0, 7));
         hz.reg_write_e = 1'($urandom);
         hz.reg_write_m = 1'($urandom);
         hz.reg_write_w = 1'($urandom);
         hz.mem_to_reg_e = ($urandom_range(0, 3) == 0);
         hz.mem_to_reg_m = ($urandom_range(0, 3) == 0);
         hz.branch_d = ($urandom_range(0, 2) == 0);
         hz.md_use_d = ($urandom_range(0, 2) == 0);
         hz.md_div_e = ($urandom_range(0, 3) == 0);
         hz.md_start_e = (cyc > mdl_end) &&
                         ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 63) == 0);
         tick();
      end
      reset = 0;
      clr();
      tick();
      tick();
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
